// File: rtl/subleq_serial_writer_if.sv
// ---------------------------------------------------------------------------
// subleq_serial_writer_if
//
// Purpose:
//   Bundles the instruction handshake, the bit-serial memory write port and
//   the branch-resolution results of the SUBLEQ write-back stage.
//
// Signals:
//   start          request to execute one instruction
//   a_val, b_val   operands A (subtrahend) and B (minuend)
//   addr_b         write-back address
//   addr_c         branch target
//   pc             address of the current instruction
//   busy           instruction in flight
//   wr_en          one strobe per result bit
//   wr_addr        write-back address being written
//   wr_bit_index   index of the bit being written
//   wr_bit         result bit value
//   done           one-cycle completion pulse
//   branch         result <= 0
//   next_pc        next instruction address
//   halted         sticky halt flag (only live with SUBLEQ_HALT_EN)
//
// Modports:
//   master  drives the instruction request, observes the results
//   slave   the write-back stage itself
// ---------------------------------------------------------------------------
interface subleq_serial_writer_if #(
  parameter int WORD_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  localparam int INDEX_WIDTH = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;

  logic                   start;
  logic [WORD_WIDTH-1:0]  a_val;
  logic [WORD_WIDTH-1:0]  b_val;
  logic [ADDR_WIDTH-1:0]  addr_b;
  logic [ADDR_WIDTH-1:0]  addr_c;
  logic [ADDR_WIDTH-1:0]  pc;
  logic                   busy;
  logic                   wr_en;
  logic [ADDR_WIDTH-1:0]  wr_addr;
  logic [INDEX_WIDTH-1:0] wr_bit_index;
  logic                   wr_bit;
  logic                   done;
  logic                   branch;
  logic [ADDR_WIDTH-1:0]  next_pc;
  logic                   halted;

  modport master (
    output start, a_val, b_val, addr_b, addr_c, pc,
    input  busy, wr_en, wr_addr, wr_bit_index, wr_bit, done, branch, next_pc, halted
  );

  modport slave (
    input  start, a_val, b_val, addr_b, addr_c, pc,
    output busy, wr_en, wr_addr, wr_bit_index, wr_bit, done, branch, next_pc, halted
  );
endinterface

// File: rtl/subleq_serial_writer.sv
// ---------------------------------------------------------------------------
// subleq_serial_writer
//
// Purpose:
//   Write-back end of the SUBLEQ datapath. Computes B - A bit-serially, LSB
//   first with a rippled borrow, writing each result bit to memory address B
//   as it is produced. After the last bit it resolves the SUBLEQ branch
//   (taken when the signed result is <= 0) and presents the next PC.
//
// Ports:
//   clock    system clock, rising edge
//   reset_n  asynchronous active-low reset
//   bus      subleq_serial_writer_if.slave: instruction request, serial
//            write port, done/branch/next_pc/halted results
//
// Configuration:
//   SUBLEQ_HALT_EN  when defined, a taken branch to the all-ones address sets
//                   a sticky halted flag, keeps next_pc at pc and blocks any
//                   further start until reset. When undefined, halted is 0
//                   and such a branch is an ordinary branch.
// ---------------------------------------------------------------------------
module subleq_serial_writer #(
  parameter int WORD_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                   clock,
  input  logic                   reset_n,
  subleq_serial_writer_if.slave  bus
);

  localparam int INDEX_WIDTH = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
  localparam logic [INDEX_WIDTH-1:0] LAST_INDEX = INDEX_WIDTH'(WORD_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [WORD_WIDTH-1:0]  a_q;
  logic [WORD_WIDTH-1:0]  b_q;
  logic [ADDR_WIDTH-1:0]  addr_b_q;
  logic [ADDR_WIDTH-1:0]  addr_c_q;
  logic [ADDR_WIDTH-1:0]  pc_q;
  logic [INDEX_WIDTH-1:0] bit_idx;
  logic                   borrow;
  logic                   nonzero;
  logic                   msb_q;
  logic                   branch_q;
  logic [ADDR_WIDTH-1:0]  next_pc_q;

  logic                   accept;
  logic                   last_bit;
  logic                   a_bit;
  logic                   b_bit;
  logic                   sum_bit;
  logic                   borrow_next;
  logic                   branch_calc;
  logic                   halt_now;
  logic                   halt_block;
  logic [ADDR_WIDTH-1:0]  target;

  // One full-subtractor slice, fed from the latched operands so the inputs
  // are free to change once the instruction has been accepted.
  always_comb begin
    a_bit       = a_q[bit_idx];
    b_bit       = b_q[bit_idx];
    sum_bit     = b_bit ^ a_bit ^ borrow;
    borrow_next = (~b_bit & a_bit) | (~(b_bit ^ a_bit) & borrow);
    last_bit    = (bit_idx == LAST_INDEX);
  end

  // Branch resolution. The final borrow is dropped, so the result is taken
  // modulo 2^WORD_WIDTH and "<= 0" means sign bit set or every bit clear.
  // The fall-through address wraps naturally at ADDR_WIDTH bits.
  always_comb begin
    branch_calc = msb_q | ~nonzero;
    halt_now    = 1'b0;
    target      = branch_calc ? addr_c_q : (pc_q + ADDR_WIDTH'(3));
`ifdef SUBLEQ_HALT_EN
    if (branch_calc && (&addr_c_q)) begin
      halt_now = 1'b1;
      target   = pc_q;
    end
`endif
  end

`ifdef SUBLEQ_HALT_EN
  logic halted_q;

  // The halt flag is sticky: it is only ever set, and only reset clears it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      halted_q <= 1'b0;
    end else if (state == DONE && halt_now) begin
      halted_q <= 1'b1;
    end
  end

  assign halt_block = halted_q;
  assign bus.halted = halted_q;
`else
  assign halt_block = 1'b0;
  assign bus.halted = 1'b0;
`endif

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and output decode. start is only looked at in IDLE, so a
  // request while busy is simply dropped rather than queued. The write strobe
  // and busy come straight from the state, so an async reset removes them
  // in the same instant.
  always_comb begin
    state_next       = state;
    accept           = 1'b0;
    bus.busy         = 1'b0;
    bus.wr_en        = 1'b0;
    bus.wr_bit       = 1'b0;
    bus.done         = 1'b0;
    bus.branch       = branch_q;
    bus.next_pc      = next_pc_q;
    bus.wr_addr      = addr_b_q;
    bus.wr_bit_index = bit_idx;
    case (state)
      IDLE: begin
        if (bus.start && !halt_block) begin
          accept     = 1'b1;
          state_next = SUB;
        end
      end
      SUB: begin
        bus.busy   = 1'b1;
        bus.wr_en  = 1'b1;
        bus.wr_bit = sum_bit;
        if (last_bit) begin
          state_next = DONE;
        end
      end
      DONE: begin
        bus.busy    = 1'b1;
        bus.done    = 1'b1;
        bus.branch  = branch_calc;
        bus.next_pc = target;
        state_next  = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Operand latches and the serial subtract state. The bit index stops on
  // the last bit so that msb_q and nonzero are final when DONE is entered;
  // branch and next_pc are registered in DONE so they hold afterwards.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      a_q       <= '0;
      b_q       <= '0;
      addr_b_q  <= '0;
      addr_c_q  <= '0;
      pc_q      <= '0;
      bit_idx   <= '0;
      borrow    <= 1'b0;
      nonzero   <= 1'b0;
      msb_q     <= 1'b0;
      branch_q  <= 1'b0;
      next_pc_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_q      <= bus.a_val;
            b_q      <= bus.b_val;
            addr_b_q <= bus.addr_b;
            addr_c_q <= bus.addr_c;
            pc_q     <= bus.pc;
            bit_idx  <= '0;
            borrow   <= 1'b0;
            nonzero  <= 1'b0;
            msb_q    <= 1'b0;
          end
        end
        SUB: begin
          borrow  <= borrow_next;
          nonzero <= nonzero | sum_bit;
          if (last_bit) begin
            msb_q <= sum_bit;
          end else begin
            bit_idx <= bit_idx + INDEX_WIDTH'(1);
          end
        end
        DONE: begin
          branch_q  <= branch_calc;
          next_pc_q <= target;
        end
        default: begin
          bit_idx <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_subleq_serial_writer.sv
// ---------------------------------------------------------------------------
// tb_subleq_serial_writer
//
// Purpose:
//   Directed self-checking bench for subleq_serial_writer with the default
//   WORD_WIDTH=8, ADDR_WIDTH=4. Inputs are driven and outputs sampled on the
//   falling clock edge, away from the active rising edge.
// ---------------------------------------------------------------------------
module tb_subleq_serial_writer;

  logic clock;
  logic reset_n;
  int   errors;
  int   checks;

  subleq_serial_writer_if #(.WORD_WIDTH(8), .ADDR_WIDTH(4)) bus ();

  subleq_serial_writer #(.WORD_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Compare one observed value with its expected value.
  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Run one instruction and check every written bit plus the branch result.
  task automatic apply_stimulus(input string tag,
                                input logic [7:0] a, input logic [7:0] b,
                                input logic [3:0] ab, input logic [3:0] ac,
                                input logic [3:0] p, input logic [7:0] exp_res,
                                input logic exp_branch, input logic [3:0] exp_pc);
    @(negedge clock);
    bus.a_val  = a;
    bus.b_val  = b;
    bus.addr_b = ab;
    bus.addr_c = ac;
    bus.pc     = p;
    bus.start  = 1'b1;
    @(negedge clock);
    bus.start  = 1'b0;
    bus.a_val  = ~a;
    bus.b_val  = b + 8'd37;
    bus.addr_b = ab + 4'd5;
    bus.addr_c = ac + 4'd1;
    bus.pc     = p + 4'd7;
    for (int i = 0; i < 8; i++) begin
      check_output({tag, " wr_en"}, 32'(bus.wr_en), 32'd1);
      check_output({tag, " busy"}, 32'(bus.busy), 32'd1);
      check_output({tag, " wr_addr"}, 32'(bus.wr_addr), 32'(ab));
      check_output({tag, " wr_bit_index"}, 32'(bus.wr_bit_index), 32'(i));
      check_output({tag, " wr_bit"}, 32'(bus.wr_bit), 32'(exp_res[i]));
      check_output({tag, " done early"}, 32'(bus.done), 32'd0);
      @(negedge clock);
    end
    check_output({tag, " done"}, 32'(bus.done), 32'd1);
    check_output({tag, " wr_en in done"}, 32'(bus.wr_en), 32'd0);
    check_output({tag, " branch"}, 32'(bus.branch), 32'(exp_branch));
    check_output({tag, " next_pc"}, 32'(bus.next_pc), 32'(exp_pc));
    @(negedge clock);
    check_output({tag, " done cleared"}, 32'(bus.done), 32'd0);
    check_output({tag, " busy cleared"}, 32'(bus.busy), 32'd0);
    check_output({tag, " branch held"}, 32'(bus.branch), 32'(exp_branch));
    check_output({tag, " next_pc held"}, 32'(bus.next_pc), 32'(exp_pc));
  endtask

  initial begin
    int writes;
    int dones;
    errors     = 0;
    checks     = 0;
    bus.start  = 1'b0;
    bus.a_val  = '0;
    bus.b_val  = '0;
    bus.addr_b = '0;
    bus.addr_c = '0;
    bus.pc     = '0;
    reset_n    = 1'b0;

    // Reset state.
    repeat (2) @(negedge clock);
    check_output("rst busy", 32'(bus.busy), 32'd0);
    check_output("rst wr_en", 32'(bus.wr_en), 32'd0);
    check_output("rst wr_bit", 32'(bus.wr_bit), 32'd0);
    check_output("rst done", 32'(bus.done), 32'd0);
    check_output("rst branch", 32'(bus.branch), 32'd0);
    check_output("rst halted", 32'(bus.halted), 32'd0);
    check_output("rst wr_addr", 32'(bus.wr_addr), 32'd0);
    check_output("rst wr_bit_index", 32'(bus.wr_bit_index), 32'd0);
    check_output("rst next_pc", 32'(bus.next_pc), 32'd0);
    reset_n = 1'b1;

    // 5 - 3 = 2, not taken, fall through to 2+3.
    apply_stimulus("t1", 8'd3, 8'd5, 4'd7, 4'd12, 4'd2, 8'h02, 1'b0, 4'd5);
    // 5 - 5 = 0, taken.
    apply_stimulus("t2", 8'd5, 8'd5, 4'd3, 4'd9, 4'd4, 8'h00, 1'b1, 4'd9);
    // 0 - 1 = 0xFF (negative), taken.
    apply_stimulus("t3", 8'd1, 8'd0, 4'd1, 4'd6, 4'd8, 8'hFF, 1'b1, 4'd6);
    // 1 - 0 = 1, not taken, 14+3 wraps to 1.
    apply_stimulus("t4", 8'd0, 8'd1, 4'd2, 4'd10, 4'd14, 8'h01, 1'b0, 4'd1);
    // -128 - 1 overflows to +127: no branch on the wrapped result.
    apply_stimulus("t5", 8'd1, 8'h80, 4'd4, 4'd11, 4'd0, 8'h7F, 1'b0, 4'd3);

    // start pulses during SUB (cycle 3) and DONE (cycle 9) are dropped.
    @(negedge clock);
    bus.a_val  = 8'd2;
    bus.b_val  = 8'd9;
    bus.addr_b = 4'd5;
    bus.addr_c = 4'd0;
    bus.pc     = 4'd3;
    bus.start  = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    writes = 0;
    dones  = 0;
    for (int k = 1; k <= 14; k++) begin
      bus.start = (k == 3 || k == 9) ? 1'b1 : 1'b0;
      if (bus.wr_en) writes++;
      if (bus.done) dones++;
      @(negedge clock);
    end
    bus.start = 1'b0;
    check_output("busy start writes", 32'(writes), 32'd8);
    check_output("busy start dones", 32'(dones), 32'd1);
    check_output("busy start next_pc", 32'(bus.next_pc), 32'd6);

    // Reset in the middle of SUB.
    @(negedge clock);
    bus.a_val = 8'd1;
    bus.b_val = 8'd0;
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    repeat (3) @(negedge clock);
    check_output("pre-reset wr_en", 32'(bus.wr_en), 32'd1);
    #1 reset_n = 1'b0;
    #1;
    check_output("mid reset wr_en", 32'(bus.wr_en), 32'd0);
    check_output("mid reset busy", 32'(bus.busy), 32'd0);
    check_output("mid reset done", 32'(bus.done), 32'd0);
    dones = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      if (k == 2) reset_n = 1'b1;
      if (bus.done) dones++;
    end
    check_output("mid reset no done", 32'(dones), 32'd0);
    check_output("mid reset idle busy", 32'(bus.busy), 32'd0);

    // 4 - 4 = 0, taken to the all-ones address.
`ifdef SUBLEQ_HALT_EN
    apply_stimulus("halt", 8'd4, 8'd4, 4'd2, 4'd15, 4'd6, 8'h00, 1'b1, 4'd6);
    check_output("halt flag", 32'(bus.halted), 32'd1);
    @(negedge clock);
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    check_output("halt start ignored busy", 32'(bus.busy), 32'd0);
    check_output("halt start ignored wr_en", 32'(bus.wr_en), 32'd0);
    check_output("halt flag sticky", 32'(bus.halted), 32'd1);
`else
    apply_stimulus("halt", 8'd4, 8'd4, 4'd2, 4'd15, 4'd6, 8'h00, 1'b1, 4'd15);
    check_output("no halt flag", 32'(bus.halted), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/subleq_serial_writer.md
Name: subleq_serial_writer

Overview:
- Write-back end of the SUBLEQ datapath. It accepts fetched operands A and B, computes B - A bit-serially (LSB first, ripple borrow), and writes each result bit back to memory at address B.
- It then resolves the SUBLEQ branch: taken when the result is <= 0, and drives the next program counter.
- Sits downstream of the operand-select/borrow logic; it is the writer for what that logic reads.

Parameters:
- WORD_WIDTH, 8, operand/result width in bits (>= 2).
- ADDR_WIDTH, 4, memory address and program counter width.

Ports:
- clock  input  1  single system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  request to execute one instruction; sampled only in IDLE.
- a_val  input  WORD_WIDTH  operand A (subtrahend).
- b_val  input  WORD_WIDTH  operand B (minuend).
- addr_b  input  ADDR_WIDTH  write-back address.
- addr_c  input  ADDR_WIDTH  branch target.
- pc  input  ADDR_WIDTH  address of the current instruction.
- busy  output  1  high from the cycle after start is accepted through the DONE cycle.
- wr_en  output  1  write strobe, one per result bit.
- wr_addr  output  ADDR_WIDTH  latched addr_b.
- wr_bit_index  output  log2(WORD_WIDTH)  index of the bit being written.
- wr_bit  output  1  result bit value.
- done  output  1  one-cycle completion pulse.
- branch  output  1  result <= 0; valid while done is high, held afterwards.
- next_pc  output  ADDR_WIDTH  next instruction address; valid while done is high, held afterwards.
- halted  output  1  sticky halt flag (Optional Feature only; tied 0 otherwise).

Behaviour:
- Reset (async, reset_n=0):
  - State IDLE.
  - busy, wr_en, wr_bit, done, branch, halted = 0.
  - wr_addr, wr_bit_index, next_pc = 0.
  - Internal borrow, bit index and nonzero flag cleared.
- States: IDLE -> SUB -> DONE -> IDLE.
- IDLE:
  - start=1 latches a_val, b_val, addr_b, addr_c and pc.
  - Clears bit index, borrow and the nonzero flag, then enters SUB.
  - start=0: remain in IDLE.
- SUB, bit i per cycle, i = 0 .. WORD_WIDTH-1:
  - wr_en=1, wr_addr=latched addr_b, wr_bit_index=i.
  - wr_bit = b[i] ^ a[i] ^ borrow.
  - borrow_next = (~b[i] & a[i]) | (~(b[i] ^ a[i]) & borrow).
  - nonzero |= wr_bit.
  - After i=WORD_WIDTH-1, enter DONE.
- DONE (exactly one cycle):
  - done=1, wr_en=0.
  - branch = msb(result) | ~nonzero, i.e. signed two's-complement result <= 0.
  - next_pc = branch ? addr_c : pc+3, modulo 2^ADDR_WIDTH (wraps).
  - Return to IDLE.
- Timing and latency:
  - start accepted on edge 0; write bits on cycles 1..WORD_WIDTH; done on cycle WORD_WIDTH+1.
  - Next start can be accepted on cycle WORD_WIDTH+2.
- Arithmetic:
  - Final borrow is discarded; results wrap modulo 2^WORD_WIDTH.
  - A signed overflow is not flagged; branch uses the wrapped result.
- Boundary conditions:
  - start while busy (SUB or DONE) is ignored; no queueing.
  - Operand inputs may change freely after acceptance; only latched values are used.
  - Reset mid-SUB: immediate return to IDLE, wr_en deasserted, partial write left as-is. done is not pulsed.
  - addr_b == pc or addr_b == addr_c is legal; the block does not check it.

Optional Feature:
- Macro: SUBLEQ_HALT_EN.
- Defined:
  - In DONE, if branch=1 and addr_c is all ones, halted is set sticky and next_pc holds pc.
  - While halted=1, start is ignored.
  - Only reset_n clears halted.
- Undefined:
  - The halted port is driven 0.
  - A branch to all ones behaves as a normal branch.

Test Plan:
- a=3, b=5, pc=2, addr_b=7, reset released -> wr_addr=7, wr_bit sequence 0,1,0,0,0,0,0,0 on cycles 1-8; done on cycle 9; branch=0, next_pc=5.
- a=5, b=5, addr_c=9 -> all written bits 0; branch=1, next_pc=9.
- a=1, b=0 -> all written bits 1 (0xFF); branch=1 (negative).
- a=0, b=1, pc=14, ADDR_WIDTH=4 -> result 1, branch=0, next_pc=1 (wrap).
- Issue start, pulse start again on cycles 3 and 9 -> both ignored, exactly 8 writes and one done. Separately, assert reset_n=0 at cycle 4 -> wr_en and busy drop immediately, no done.
- With SUBLEQ_HALT_EN: a=b=4, addr_c=15 -> halted=1, next_pc=pc, later start ignored. Without the macro -> halted=0, next_pc=15.
